// File: rtl/opcode_pkg.sv
// Shared constants and types for the opcode issuing path.
// The arbitration variant is selected by OPCODE_ENC_RR_EN (round-robin when defined).
package opcode_pkg;

    localparam logic       OP_PFX_A = 1'b1;
    localparam logic [1:0] OP_PFX_B = 2'b01;
    localparam logic [2:0] OP_PFX_C = 3'b001;
    localparam logic [3:0] OP_IDLE  = 4'b0000;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    typedef enum logic [1:0] {
        CLS_A = 2'd0,
        CLS_B = 2'd1,
        CLS_C = 2'd2
    } cls_e;

    // Recovers the requester class from an issued opcode using the decoder's priority.
    function automatic cls_e opcode_class(input logic [3:0] op);
        if (op[3]) begin
            return CLS_A;
        end else if (op[2]) begin
            return CLS_B;
        end else begin
            return CLS_C;
        end
    endfunction

endpackage

// File: rtl/opcode_arbiter.sv
// One-hot grant selection over requesters A (bit 0), B (bit 1), C (bit 2).
// OPCODE_ENC_RR_EN selects round-robin starting after the last granted class; otherwise A > B > C.
module opcode_arbiter
    import opcode_pkg::*;
(
`ifdef OPCODE_ENC_RR_EN
    input  cls_e       ptr,
`endif
    input  logic [2:0] req,
    output logic [2:0] grant
);

`ifdef OPCODE_ENC_RR_EN
    always_comb begin
        grant = 3'b000;
        case (ptr)
            CLS_A: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            CLS_B: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        grant = 3'b000;
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
    end
`endif

endmodule

// File: rtl/opcode_encoder.sv
// Arbitrates requesters A/B/C into class-prefixed opcodes behind a one-entry valid/ready stage.
// Define OPCODE_ENC_RR_EN for round-robin arbitration; default is fixed priority A > B > C.
module opcode_encoder
    import opcode_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             req_c,
    input  logic [2:0]       tag_a,
    input  logic [1:0]       tag_b,
    input  logic             tag_c,
    output logic             grant_a,
    output logic             grant_b,
    output logic             grant_c,
    output logic [3:0]       opcode,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e     state;
    logic       capture_ok;
    logic       handshake;
    logic [2:0] req_vec;
    logic [2:0] grant;
    logic [3:0] next_opcode;
    cls_e       xfer_cls;

    // Grants are suppressed while reset is asserted so a held request is never lost.
    assign capture_ok = reset_n && ((state == ST_EMPTY) || op_ready);
    assign req_vec    = {req_c, req_b, req_a} & {3{capture_ok}};
    assign handshake  = op_valid && op_ready;
    assign xfer_cls   = opcode_class(opcode);

`ifdef OPCODE_ENC_RR_EN
    cls_e rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= CLS_A;
        end else if (grant[0]) begin
            rr_ptr <= CLS_A;
        end else if (grant[1]) begin
            rr_ptr <= CLS_B;
        end else if (grant[2]) begin
            rr_ptr <= CLS_C;
        end
    end

    opcode_arbiter u_arbiter (
        .ptr   (rr_ptr),
        .req   (req_vec),
        .grant (grant)
    );
`else
    opcode_arbiter u_arbiter (
        .req   (req_vec),
        .grant (grant)
    );
`endif

    assign grant_a = grant[0];
    assign grant_b = grant[1];
    assign grant_c = grant[2];

    always_comb begin
        next_opcode = OP_IDLE;
        if (grant[0]) begin
            next_opcode = {OP_PFX_A, tag_a};
        end else if (grant[1]) begin
            next_opcode = {OP_PFX_B, tag_b};
        end else if (grant[2]) begin
            next_opcode = {OP_PFX_C, tag_c};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_EMPTY;
            opcode   <= OP_IDLE;
            op_valid <= 1'b0;
        end else if (|grant) begin
            state    <= ST_FULL;
            opcode   <= next_opcode;
            op_valid <= 1'b1;
        end else if ((state == ST_FULL) && op_ready) begin
            state    <= ST_EMPTY;
            opcode   <= OP_IDLE;
            op_valid <= 1'b0;
        end
    end

    // Counters track completed transfers, keyed by the opcode leaving the stage.
    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
        end else if (handshake) begin
            case (xfer_cls)
                CLS_A:   if (cnt_a != CNT_MAX) cnt_a <= cnt_a + 1'b1;
                CLS_B:   if (cnt_b != CNT_MAX) cnt_b <= cnt_b + 1'b1;
                default: if (cnt_c != CNT_MAX) cnt_c <= cnt_c + 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder with a transaction-level reference model checked every cycle.
// Model and expected orders follow OPCODE_ENC_RR_EN when it is defined.
module tb_opcode_encoder;

    localparam int CNT_W   = 2;
    localparam int CNT_SAT = 3;

    logic             clk;
    logic             reset_n;
    logic             req_a, req_b, req_c;
    logic [2:0]       tag_a;
    logic [1:0]       tag_b;
    logic             tag_c;
    logic             grant_a, grant_b, grant_c;
    logic [3:0]       opcode;
    logic             op_valid;
    logic             op_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;

    int errors = 0;
    int checks = 0;

    // Reference model state: one held transaction plus per-class transfer counts.
    bit m_known = 0;
    int m_valid = 0;
    int m_op    = 0;
    int m_cls   = 0;
    int m_last  = 0;
    int m_cnt[3];

    opcode_encoder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .tag_a    (tag_a),
        .tag_b    (tag_b),
        .tag_c    (tag_c),
        .grant_a  (grant_a),
        .grant_b  (grant_b),
        .grant_c  (grant_c),
        .opcode   (opcode),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .cnt_clr  (cnt_clr),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_grant();
        bit r[3];
        r[0] = req_a;
        r[1] = req_b;
        r[2] = req_c;
        if (!reset_n) return -1;
        if (m_valid != 0 && !op_ready) return -1;
`ifdef OPCODE_ENC_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(m_last + k) % 3]) return (m_last + k) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin : model_update
        int g;
        g = exp_grant();
        if (!reset_n) begin
            m_known = 1;
            m_valid = 0;
            m_op    = 0;
            m_last  = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            if (cnt_clr) begin
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else if (m_valid != 0 && op_ready) begin
                if (m_cnt[m_cls] < CNT_SAT) m_cnt[m_cls] = m_cnt[m_cls] + 1;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_cls   = g;
                m_last  = g;
                case (g)
                    0:       m_op = 8 + int'(tag_a);
                    1:       m_op = 4 + int'(tag_b);
                    default: m_op = 2 + int'(tag_c);
                endcase
            end else if (m_valid != 0 && op_ready) begin
                m_valid = 0;
                m_op    = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int g;
        if (m_known) begin
            g = exp_grant();
            checkOutput("model_grant", {29'd0, grant_c, grant_b, grant_a},
                        (g < 0) ? 32'd0 : (32'd1 << g));
            checkOutput("model_valid", {31'd0, op_valid}, m_valid);
            checkOutput("model_opcode", {28'd0, opcode}, m_op);
            checkOutput("model_cnt_a", {30'd0, cnt_a}, m_cnt[0]);
            checkOutput("model_cnt_b", {30'd0, cnt_b}, m_cnt[1]);
            checkOutput("model_cnt_c", {30'd0, cnt_c}, m_cnt[2]);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic c,
                                 input logic [2:0] ta, input logic [1:0] tb, input logic tc,
                                 input logic rdy, input logic clr, input logic rstn);
        req_a    = a;
        req_b    = b;
        req_c    = c;
        tag_a    = ta;
        tag_b    = tb;
        tag_c    = tc;
        op_ready = rdy;
        cnt_clr  = clr;
        reset_n  = rstn;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        wait_neg();
        wait_pos();
    endtask

    int         ord[3];
    logic [3:0] ops[3];

    initial begin
        applyStimulus(1, 0, 0, 3'd0, 2'd0, 1'b0, 1, 0, 0);
        wait_pos();
        wait_neg();
        checkOutput("reset_grant_a", {31'd0, grant_a}, 0);
        wait_pos();
        wait_neg();
        checkOutput("reset_opcode", {28'd0, opcode}, 0);
        checkOutput("reset_valid", {31'd0, op_valid}, 0);
        checkOutput("reset_cnt", {26'd0, cnt_a, cnt_b, cnt_c}, 0);
        wait_pos();

        // Single class-B request.
        applyStimulus(0, 1, 0, 3'd0, 2'b11, 1'b0, 1, 0, 1);
        wait_neg();
        checkOutput("single_b_grant", {29'd0, grant_c, grant_b, grant_a}, 3'b010);
        wait_pos();
        applyStimulus(0, 0, 0, 3'd0, 2'd0, 1'b0, 1, 0, 1);
        wait_neg();
        checkOutput("single_b_opcode", {28'd0, opcode}, 4'b0111);
        checkOutput("single_b_valid", {31'd0, op_valid}, 1);
        wait_pos();
        wait_neg();
        checkOutput("single_b_cnt", {30'd0, cnt_b}, 1);
        wait_pos();

        // All three requesting after a fresh reset.
        applyStimulus(0, 0, 0, 3'd0, 2'd0, 1'b0, 1, 0, 0);
        tick();
        tick();
`ifdef OPCODE_ENC_RR_EN
        ord[0] = 1; ord[1] = 2; ord[2] = 0;
        ops[0] = 4'b0101; ops[1] = 4'b0011; ops[2] = 4'b1010;
`else
        ord[0] = 0; ord[1] = 1; ord[2] = 2;
        ops[0] = 4'b1010; ops[1] = 4'b0101; ops[2] = 4'b0011;
`endif
        applyStimulus(1, 1, 1, 3'b010, 2'b01, 1'b1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            wait_neg();
            checkOutput("prio_grant", {29'd0, grant_c, grant_b, grant_a}, 32'd1 << ord[k]);
            if (k > 0) checkOutput("prio_opcode", {28'd0, opcode}, ops[k-1]);
            wait_pos();
            case (ord[k])
                0:       req_a = 1'b0;
                1:       req_b = 1'b0;
                default: req_c = 1'b0;
            endcase
        end
        wait_neg();
        checkOutput("prio_opcode_last", {28'd0, opcode}, ops[2]);
        wait_pos();

        // Backpressure: C with tag 0 held while A waits.
        applyStimulus(0, 0, 1, 3'd0, 2'd0, 1'b0, 0, 0, 1);
        wait_neg();
        checkOutput("bp_grant_c", {31'd0, grant_c}, 1);
        wait_pos();
        applyStimulus(1, 0, 0, 3'b101, 2'd0, 1'b0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            wait_neg();
            checkOutput("bp_hold_opcode", {28'd0, opcode}, 4'b0010);
            checkOutput("bp_hold_grant_a", {31'd0, grant_a}, 0);
            wait_pos();
        end
        op_ready = 1'b1;
        wait_neg();
        checkOutput("bp_release_grant_a", {31'd0, grant_a}, 1);
        wait_pos();
        req_a = 1'b0;
        wait_neg();
        checkOutput("bp_release_opcode", {28'd0, opcode}, 4'b1101);

        // Five class-C transfers saturate a 2-bit counter.
        wait_pos();
        applyStimulus(0, 0, 1, 3'd0, 2'd0, 1'b1, 1, 1, 1);
        wait_neg();
        wait_pos();
        cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        req_c = 1'b0;
        tick();
        wait_neg();
        checkOutput("sat_cnt_c", {30'd0, cnt_c}, CNT_SAT);
        wait_pos();
        applyStimulus(0, 0, 1, 3'd0, 2'd0, 1'b1, 1, 0, 1);
        tick();
        req_c   = 1'b0;
        cnt_clr = 1'b1;
        wait_neg();
        wait_pos();
        cnt_clr = 1'b0;
        wait_neg();
        checkOutput("clr_with_handshake", {30'd0, cnt_c}, 0);
        wait_pos();

        // Reset while a held opcode is stalled.
        applyStimulus(1, 0, 0, 3'b111, 2'd0, 1'b0, 0, 0, 1);
        tick();
        tick();
        applyStimulus(1, 0, 0, 3'b111, 2'd0, 1'b0, 0, 0, 0);
        wait_neg();
        checkOutput("midrst_grant", {29'd0, grant_c, grant_b, grant_a}, 0);
        wait_pos();
        wait_neg();
        checkOutput("midrst_valid", {31'd0, op_valid}, 0);
        checkOutput("midrst_opcode", {28'd0, opcode}, 0);
        wait_pos();
        op_ready = 1'b1;
        wait_neg();
        checkOutput("midrst_ready_grant", {29'd0, grant_c, grant_b, grant_a}, 0);
        wait_pos();
        applyStimulus(0, 0, 0, 3'd0, 2'd0, 1'b0, 1, 0, 1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/opcode_encoder.md
# opcode_encoder

Issuing side of the 4-bit opcode format consumed by the opcode casex decoder: arbitrates between three requesters (A, B, C), encodes the winner and its tag bits into an opcode of the matching class (1xxx, 01xx, 001x), and presents it on a registered valid/ready output. The idle opcode 4'b0000 selects the decoder's default branch. The block sits between the command sources and the decoder, one clock domain, and keeps per-class issue counters for debug.

## Interface
- CNT_W, 8, width of each per-class saturating issue counter
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- req_a / req_b / req_c  input  1 each  request; held high with tag stable until granted
- tag_a  input  3  payload for opcode[2:0] of class A
- tag_b  input  2  payload for opcode[1:0] of class B
- tag_c  input  1  payload for opcode[0] of class C
- grant_a / grant_b / grant_c  output  1 each  one-hot pulse, cycle the request is captured
- opcode  output  4  encoded opcode, 4'b0000 whenever op_valid=0
- op_valid  output  1  opcode holds a valid command
- op_ready  input  1  downstream accepts opcode when op_valid && op_ready
- cnt_clr  input  1  synchronous clear of all counters
- cnt_a / cnt_b / cnt_c  output  CNT_W each  issued-opcode counts per class

## Operation
- Encoding: A -> {1'b1, tag_a}; B -> {2'b01, tag_b}; C -> {3'b001, tag_c}. Never emit 4'b0000 as a valid opcode; C with tag_c=0 gives 4'b0010.
- FSM, two states: EMPTY (op_valid=0), FULL (op_valid=1).
- Capture allowed when state=EMPTY, or state=FULL && op_ready (pass-through, 1 opcode/cycle sustained).
- Capture with any request: assert the winner's grant, load opcode, go/stay FULL.
- FULL && op_ready with no request: go EMPTY, opcode -> 0000.
- FULL && !op_ready: hold opcode, no grants, requests wait.
- Arbitration (default): fixed priority A > B > C, identical to decoder priority.
- Counters: on each accepted handshake (op_valid && op_ready) increment the counter of the class being transferred; saturate at 2^CNT_W-1. cnt_clr wins over a simultaneous increment (result 0).
- Reset (reset_n=0 at clock edge): state EMPTY, opcode 0000, op_valid 0, grants 0, counters 0, round-robin pointer = A. Reset mid-transfer discards the held opcode; no grant issued that cycle.

## Timing
- Grant is combinational from req, state and op_ready; asserted in cycle N; opcode/op_valid registered, visible cycle N+1.
- Request-to-valid latency 1 cycle; back-to-back grants every cycle while op_ready=1.
- Counter updates visible the cycle after the handshake.
- Requester must drop or change req on the cycle after its grant; a held req is treated as a new request.

## Configuration
- OPCODE_ENC_RR_EN defined: round-robin arbitration; a 2-bit pointer records the last granted class, search order starts at the next class (A->B->C->A); pointer updates only on grant.
- Undefined: fixed priority A > B > C, no pointer register.

## Structure
- Shared package opcode_pkg: class prefix constants (OP_PFX_A=1'b1, OP_PFX_B=2'b01, OP_PFX_C=3'b001), OP_IDLE=4'b0000, state typedef (ST_EMPTY, ST_FULL), class-index typedef.
- One sub-module opcode_arbiter: req vector + pointer -> one-hot grant; holds both fixed and round-robin variants under the macro.

## Test plan
- Reset: reset_n=0 two cycles with req_a=1 -> opcode=0000, op_valid=0, grants=0, counters=0.
- Single B: req_b=1, tag_b=2'b11, op_ready=1 -> grant_b cycle N, opcode=4'b0111 op_valid=1 cycle N+1, cnt_b=1 after transfer.
- Priority: req_a=req_b=req_c=1, tags 3'b010/2'b01/1'b1 -> fixed: opcodes 1010, 0101, 0011 in consecutive cycles; RR_EN with pointer=A after reset: B first (0101), then C (0011), then A (1010).
- Backpressure: opcode 0010 valid, op_ready=0 for 5 cycles with req_a=1 -> opcode held 0010, grant_a=0 throughout; op_ready=1 -> grant_a that cycle, 1xxx next.
- Saturation/clear: CNT_W=2, issue 5 class-C opcodes -> cnt_c=3; cnt_clr coincident with a handshake -> cnt_c=0.
- Mid-operation reset: reset_n=0 while FULL with op_ready=0 -> next cycle op_valid=0, opcode=0000, no grant.
